// File: rtl/image_pkg.sv
// Shared definitions for the BMP frame writer: FSM encoding, BMP header
// constants and the header byte generator.
package image_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CAPTURE = 3'd1,
    HDR     = 3'd2,
    PIX     = 3'd3,
    DONE    = 3'd4
  } img_state_t;

  localparam int BMP_HDR_BYTES = 54;
  localparam int BMP_DIB_BYTES = 40;
  localparam int BMP_BPP       = 24;

  function automatic logic [7:0] le_byte(input logic [31:0] v, input logic [1:0] k);
    return v[{k, 3'b000} +: 8];
  endfunction

  // Every 4-byte field we emit starts at an offset whose low bits are 2'b10,
  // so idx[1:0]-2 is the byte lane within that field.
  function automatic logic [7:0] bmp_hdr_byte(input logic [5:0]  idx,
                                              input logic [31:0] w,
                                              input logic [31:0] h);
    logic [31:0] img_sz;
    logic [31:0] file_sz;
    logic [1:0]  k;
    logic [7:0]  b;
    img_sz  = 32'd3 * w * h;
    file_sz = img_sz + 32'(BMP_HDR_BYTES);
    k       = idx[1:0] - 2'd2;
    b       = 8'h00;
    case (idx)
      6'd0:                    b = 8'h42;
      6'd1:                    b = 8'h4D;
      6'd2, 6'd3, 6'd4, 6'd5:  b = le_byte(file_sz, k);
      6'd10:                   b = 8'(BMP_HDR_BYTES);
      6'd14:                   b = 8'(BMP_DIB_BYTES);
      6'd18, 6'd19, 6'd20, 6'd21: b = le_byte(w, k);
      6'd22, 6'd23, 6'd24, 6'd25: b = le_byte(h, k);
      6'd26:                   b = 8'd1;
      6'd28:                   b = 8'(BMP_BPP);
      6'd34, 6'd35, 6'd36, 6'd37: b = le_byte(img_sz, k);
      default:                 b = 8'h00;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/pixel_bank.sv
// Simple dual-port pixel store: one write port, one registered read port.
// Contents are intentionally not reset.
module pixel_bank #(
  parameter int DEPTH = 196608,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          HCLK,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [23:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [23:0]   rdata
);

  logic [23:0] mem [DEPTH];

  always_ff @(posedge HCLK) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge HCLK) begin
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/image_write.sv
// Captures one frame of pixel pairs into two banks, then streams it out as a
// 24-bit bottom-up BMP file over a valid/ready byte interface.
//
// state   | meaning
// IDLE    | wait for VSYNC
// CAPTURE | write pixel pairs, VSYNC restarts the frame
// HDR     | emit 54-byte BMP header
// PIX     | emit pixel bytes, last row first, B,G,R per pixel
// DONE    | one-cycle write_done, back to IDLE
module image_write
  import image_pkg::*;
#(
  parameter int WIDTH  = 768,
  parameter int HEIGHT = 512
) (
  input  logic       HCLK,
  input  logic       HRESET,
  input  logic       VSYNC,
  input  logic       HSYNC,
  input  logic [7:0] DATA_R0,
  input  logic [7:0] DATA_G0,
  input  logic [7:0] DATA_B0,
  input  logic [7:0] DATA_R1,
  input  logic [7:0] DATA_G1,
  input  logic [7:0] DATA_B1,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       frame_done,
  output logic       write_done
);

  localparam int NPAIRS = WIDTH * HEIGHT / 2;
  localparam int HALF   = WIDTH / 2;
  localparam int TOTAL  = BMP_HDR_BYTES + 3 * WIDTH * HEIGHT;
  localparam int AW     = (NPAIRS > 1) ? $clog2(NPAIRS) : 1;
  localparam int BW     = $clog2(TOTAL + 1);
  localparam int CW     = $clog2(WIDTH);
  localparam int RW     = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam logic [AW-1:0] RD_BASE_INIT = AW'((HEIGHT - 1) * HALF);

  img_state_t state, state_nxt;

  logic [RW-1:0] row;
  logic [CW-1:0] col;
  logic [AW-1:0] wr_addr;
  logic [BW-1:0] byte_cnt;
  logic [CW-1:0] out_col, next_col;
  logic [AW-1:0] rd_base, next_base, raddr;
  logic [1:0]    sub;
  logic [23:0]   rdata_even, rdata_odd, pix_word;
  logic [7:0]    pix_byte, hdr_byte;
  logic          take, slot_free, more;
  logic          cap_beat, cap_last, hdr_load, pix_load, pix_adv, row_end;

  assign take      = out_valid & out_ready;
  assign slot_free = ~out_valid | out_ready;
  assign more      = byte_cnt < BW'(TOTAL);
  assign cap_beat  = (state == CAPTURE) && HSYNC && !VSYNC;
  assign cap_last  = (row == RW'(HEIGHT - 1)) && (col == CW'(WIDTH - 2));
  assign hdr_load  = (state == HDR) && slot_free;
  assign pix_load  = (state == PIX) && slot_free && more;
  assign pix_adv   = pix_load && (sub == 2'd2);
  assign row_end   = (out_col == CW'(WIDTH - 1));

  assign frame_done = cap_beat && cap_last;
  assign write_done = (state == DONE);

  // The read address always targets the pixel that will be current after this
  // edge, so the registered bank output is ready with no bubble.
  assign next_col  = row_end ? '0 : out_col + CW'(1);
  assign next_base = row_end ? rd_base - AW'(HALF) : rd_base;
  assign raddr     = pix_adv ? next_base + AW'(next_col[CW-1:1])
                             : rd_base + AW'(out_col[CW-1:1]);

  assign hdr_byte = bmp_hdr_byte(byte_cnt[5:0], 32'(WIDTH), 32'(HEIGHT));
  assign pix_word = out_col[0] ? rdata_odd : rdata_even;

  always_comb begin
    pix_byte = pix_word[23:16];
    case (sub)
      2'd0:    pix_byte = pix_word[7:0];
      2'd1:    pix_byte = pix_word[15:8];
      default: pix_byte = pix_word[23:16];
    endcase
  end

  pixel_bank #(.DEPTH(NPAIRS), .AW(AW)) u_bank_even (
    .HCLK  (HCLK),
    .we    (cap_beat),
    .waddr (wr_addr),
    .wdata ({DATA_R0, DATA_G0, DATA_B0}),
    .raddr (raddr),
    .rdata (rdata_even)
  );

  pixel_bank #(.DEPTH(NPAIRS), .AW(AW)) u_bank_odd (
    .HCLK  (HCLK),
    .we    (cap_beat),
    .waddr (wr_addr),
    .wdata ({DATA_R1, DATA_G1, DATA_B1}),
    .raddr (raddr),
    .rdata (rdata_odd)
  );

  always_ff @(posedge HCLK or negedge HRESET) begin
    if (!HRESET) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (VSYNC) state_nxt = CAPTURE;
      CAPTURE: if (cap_beat && cap_last) state_nxt = HDR;
      HDR:     if (hdr_load && byte_cnt == BW'(BMP_HDR_BYTES - 1)) state_nxt = PIX;
      PIX:     if (take && !more) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESET) begin
    if (!HRESET) begin
      row       <= '0;
      col       <= '0;
      wr_addr   <= '0;
      byte_cnt  <= '0;
      out_col   <= '0;
      rd_base   <= '0;
      sub       <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          row       <= '0;
          col       <= '0;
          wr_addr   <= '0;
          byte_cnt  <= '0;
          out_col   <= '0;
          rd_base   <= RD_BASE_INIT;
          sub       <= '0;
          out_valid <= 1'b0;
        end
        CAPTURE: begin
          if (VSYNC) begin
            row     <= '0;
            col     <= '0;
            wr_addr <= '0;
          end else if (HSYNC) begin
            wr_addr <= wr_addr + AW'(1);
            if (col == CW'(WIDTH - 2)) begin
              col <= '0;
              row <= cap_last ? '0 : row + RW'(1);
            end else begin
              col <= col + CW'(2);
            end
          end
        end
        HDR: begin
          if (hdr_load) begin
            out_data  <= hdr_byte;
            out_valid <= 1'b1;
            byte_cnt  <= byte_cnt + BW'(1);
          end
        end
        PIX: begin
          if (pix_load) begin
            out_data  <= pix_byte;
            out_valid <= 1'b1;
            byte_cnt  <= byte_cnt + BW'(1);
            sub       <= (sub == 2'd2) ? 2'd0 : sub + 2'd1;
            if (pix_adv) begin
              out_col <= next_col;
              rd_base <= next_base;
            end
          end else if (slot_free) begin
            out_valid <= 1'b0;
          end
        end
        default: out_valid <= 1'b0;
      endcase
    end
  end

endmodule

// File: doc/image_write.md
IMAGE_WRITE -- requirements
Module: image_write

Interface
REQ-001 SHALL have parameter WIDTH, default 768: pixels per line; even and a multiple of 4, so BMP rows need no padding.
REQ-002 SHALL have parameter HEIGHT, default 512: lines per frame.
REQ-003 SHALL have port HCLK, input, 1: sole clock, rising edge.
REQ-004 SHALL have port HRESET, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port VSYNC, input, 1: frame-start interval marker from the pixel source.
REQ-006 SHALL have port HSYNC, input, 1: pixel-pair valid; one pair is accepted per cycle while high.
REQ-007 SHALL have ports DATA_R0, DATA_G0, DATA_B0, input, 8 each: even pixel RGB.
REQ-008 SHALL have ports DATA_R1, DATA_G1, DATA_B1, input, 8 each: odd pixel RGB.
REQ-009 SHALL have port out_data, output, 8: BMP byte stream.
REQ-010 SHALL have port out_valid, output, 1: out_data holds a valid byte.
REQ-011 SHALL have port out_ready, input, 1: sink accepts the byte.
REQ-012 SHALL have port frame_done, output, 1: one-cycle pulse when the last pixel pair is captured.
REQ-013 SHALL have port write_done, output, 1: one-cycle pulse when the last BMP byte is accepted.

Function
REQ-014 SHALL implement states IDLE, CAPTURE, HDR, PIX, DONE.
REQ-015 IDLE->CAPTURE SHALL occur on the first cycle with VSYNC=1; row and column counters clear to 0.
REQ-016 In CAPTURE, each HSYNC=1 cycle SHALL write the even pixel to (row, col) and the odd pixel to (row, col+1).
REQ-017 In CAPTURE, col SHALL advance by 2; when col=WIDTH-2, col SHALL go to 0 and row SHALL increment.
REQ-018 After WIDTH*HEIGHT/2 accepted pairs, the FSM SHALL go to HDR and frame_done SHALL pulse in the same cycle as the final write.
REQ-019 VSYNC=1 during CAPTURE SHALL restart the capture: counters go to 0, and already-written data is overwritten later.
REQ-020 HSYNC and VSYNC SHALL be ignored in HDR, PIX and DONE; no RAM writes occur in those states.
REQ-021 HDR SHALL emit the standard 54-byte BMP header, all multi-byte fields little-endian: "BM"; file size=54+3*W*H; reserved=0; offset=54; DIB size=40; width=W; height=H; planes=1; bpp=24; compression=0; image size=3*W*H; resolutions, colours and important colours=0.
REQ-022 PIX SHALL emit rows bottom-up: row HEIGHT-1 first, row 0 last.
REQ-023 Within a row, PIX SHALL emit pixels left to right, each as bytes B, G, R.
REQ-024 Handshake: a byte transfers when out_valid&&out_ready; while out_valid=1 and out_ready=0, out_data SHALL hold stable.
REQ-025 out_valid SHALL not drop until the byte is taken, and SHALL be 0 outside HDR and PIX.
REQ-026 The first header byte SHALL be valid no later than 2 cycles after entering HDR.
REQ-027 With out_ready held at 1, the stream SHALL sustain one byte per cycle, except for at most 2 cycles of RAM-read latency at the HDR->PIX boundary.
REQ-028 On acceptance of the last pixel byte, the FSM SHALL go to DONE; DONE SHALL last one cycle with write_done=1, then go to IDLE.
REQ-029 Byte counters SHALL be wide enough for 54+3*W*H with no wrap-around at the default parameters.

Reset
REQ-030 HRESET=0 SHALL asynchronously force state=IDLE and clear all counters.
REQ-031 HRESET=0 SHALL force out_valid=0, out_data=0, frame_done=0 and write_done=0.
REQ-032 Reset mid-capture or mid-stream SHALL abandon the frame; the RAM contents are not cleared.
REQ-033 After reset is released, the next VSYNC SHALL start a fresh frame.

Structure
REQ-034 Package image_pkg SHALL hold the state encoding, BMP_HDR_BYTES=54, BMP_DIB_BYTES=40 and BMP_BPP=24.
REQ-035 Storage SHALL be two instances of sub-module pixel_bank, one for even and one for odd pixels.
REQ-036 pixel_bank SHALL be a simple dual-port RAM of WIDTH*HEIGHT/2 x 24 bits, with 1 write port and 1 registered read port.

Verification (bench W=4, H=2)
REQ-037 SHALL cover: reset, VSYNC, 4 HSYNC beats, out_ready=1 -> frame_done after beat 4; 54+24 bytes output, then write_done; bytes 0-1 = 0x42,0x4D.
REQ-038 SHALL cover: header check -> bytes 2-5 = 0x4E,0,0,0 (78); bytes 18-21 = 4; bytes 22-25 = 2; bytes 28-29 = 0x18,0.
REQ-039 SHALL cover: pixel (row1,col0)=R0x11/G0x22/B0x33 -> bytes 54-56 = 0x33,0x22,0x11; row 0 data starts at byte 66.
REQ-040 SHALL cover: out_ready toggled randomly -> identical byte sequence, out_data stable during every stall.
REQ-041 SHALL cover: HRESET low after 2 beats, then a full frame -> output matches the second frame only.
REQ-042 SHALL cover: VSYNC reasserted after beat 3 plus 4 new beats -> output reflects the new beats only; HSYNC during PIX has no effect on the output.
